// File: rtl/bounded_updown_counter_pkg.sv
// Shared mode encodings and helpers for the bounded up/down counter.
package bounded_updown_counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SAT      = 2'd0,
    MODE_WRAP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  function automatic logic is_pingpong(input mode_e m);
    return (m == MODE_PINGPONG);
  endfunction

endpackage

// File: rtl/bounded_updown_counter_if.sv
// Control and status bundle of the bounded up/down counter.
interface bounded_updown_counter_if
  import bounded_updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic              Clear;
  logic              Load;
  logic [WIDTH-1:0]  LoadValue;
  logic              Enable;
  logic              UpDownMode;
  logic [MODE_W-1:0] Mode;
  logic [WIDTH-1:0]  Step;
  logic [WIDTH-1:0]  Output;
  logic              Direction;
  logic              LimitReachedFlag;
  logic              WrapPulse;

  modport master (
    output Clear, Load, LoadValue, Enable, UpDownMode, Mode, Step,
    input  Output, Direction, LimitReachedFlag, WrapPulse
  );

  modport slave (
    input  Clear, Load, LoadValue, Enable, UpDownMode, Mode, Step,
    output Output, Direction, LimitReachedFlag, WrapPulse
  );

endinterface

// File: rtl/bounded_updown_counter_next_value.sv
// Combinational next-count calculation for one enabled step in the selected mode.
module bounded_updown_counter_next_value
  import bounded_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int MIN_VALUE = 0
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] step,
  input  logic             dir_up,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_value,
  output logic             hit,
  output logic             wrap
);

  // One guard bit so sums past MAX are seen before truncation.
  localparam logic [WIDTH:0] MIN_X   = (WIDTH+1)'(MIN_VALUE);
  localparam logic [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0] SPAN_X  = MAX_X - MIN_X;
  localparam logic [WIDTH:0] RANGE_X = SPAN_X + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] val_x_s;
  logic [WIDTH:0] step_c_s;
  logic [WIDTH:0] sum_x_s;
  logic [WIDTH:0] low_lim_s;

  assign val_x_s   = {1'b0, value};
  assign step_c_s  = ({1'b0, step} > SPAN_X) ? SPAN_X : {1'b0, step};
  assign sum_x_s   = val_x_s + step_c_s;
  assign low_lim_s = MIN_X + step_c_s;

  // Bound test and result selection per mode and direction.
  always_comb begin
    next_value = value;
    hit        = 1'b0;
    wrap       = 1'b0;
    case (mode)
      MODE_WRAP: begin
        if (dir_up) begin
          if (sum_x_s > MAX_X) begin
            next_value = WIDTH'(sum_x_s - RANGE_X);
            hit        = 1'b1;
            wrap       = 1'b1;
          end else begin
            next_value = WIDTH'(sum_x_s);
          end
        end else begin
          if (val_x_s < low_lim_s) begin
            next_value = WIDTH'(val_x_s + RANGE_X - step_c_s);
            hit        = 1'b1;
            wrap       = 1'b1;
          end else begin
            next_value = WIDTH'(val_x_s - step_c_s);
          end
        end
      end
      MODE_PINGPONG: begin
        if (dir_up) begin
          if (sum_x_s >= MAX_X) begin
            next_value = WIDTH'(MAX_X);
            hit        = 1'b1;
            wrap       = 1'b1;
          end else begin
            next_value = WIDTH'(sum_x_s);
          end
        end else begin
          if (val_x_s <= low_lim_s) begin
            next_value = WIDTH'(MIN_X);
            hit        = 1'b1;
            wrap       = 1'b1;
          end else begin
            next_value = WIDTH'(val_x_s - step_c_s);
          end
        end
      end
      default: begin
        if (dir_up) begin
          if (sum_x_s >= MAX_X) begin
            next_value = WIDTH'(MAX_X);
            hit        = 1'b1;
          end else begin
            next_value = WIDTH'(sum_x_s);
          end
        end else begin
          if (val_x_s <= low_lim_s) begin
            next_value = WIDTH'(MIN_X);
            hit        = 1'b1;
          end else begin
            next_value = WIDTH'(val_x_s - step_c_s);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter: state registers and Clear > Load > Enable priority mux.
module bounded_updown_counter
  import bounded_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter int MIN_VALUE = 0
) (
  input  logic                      Clk,
  input  logic                      ResetN,
  bounded_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

  // Returns {clamped, value} for a parallel load.
  function automatic logic [WIDTH:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    if (v > MAX_W) begin
      r = {1'b1, MAX_W};
    end else if (v < MIN_W) begin
      r = {1'b1, MIN_W};
    end else begin
      r = {1'b0, v};
    end
    return r;
  endfunction

  mode_e            mode_s;
  logic             count_s;
  logic             eff_dir_s;
  logic [WIDTH-1:0] step_next_s;
  logic             hit_s;
  logic             wrap_s;
  logic [WIDTH:0]   load_c_s;

  logic [WIDTH-1:0] count_r;
  logic             dir_r;
  logic             lim_r;
  logic             wrap_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             dir_nxt_s;
  logic             lim_nxt_s;
  logic             wrap_nxt_s;

  assign mode_s    = mode_e'(bus.Mode);
  assign count_s   = bus.Enable & (bus.Step != {WIDTH{1'b0}});
  assign eff_dir_s = is_pingpong(mode_s) ? dir_r : bus.UpDownMode;
  assign load_c_s  = clamp_load(bus.LoadValue);

  bounded_updown_counter_next_value #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE),
    .MIN_VALUE (MIN_VALUE)
  ) u_next (
    .value      (count_r),
    .step       (bus.Step),
    .dir_up     (eff_dir_s),
    .mode       (mode_s),
    .next_value (step_next_s),
    .hit        (hit_s),
    .wrap       (wrap_s)
  );

  // Priority selection of the next register contents.
  always_comb begin
    count_nxt_s = count_r;
    dir_nxt_s   = dir_r;
    lim_nxt_s   = lim_r;
    wrap_nxt_s  = 1'b0;
    if (bus.Clear) begin
      count_nxt_s = MIN_W;
      dir_nxt_s   = bus.UpDownMode;
      lim_nxt_s   = 1'b0;
    end else if (bus.Load) begin
      count_nxt_s = load_c_s[WIDTH-1:0];
      dir_nxt_s   = bus.UpDownMode;
      lim_nxt_s   = load_c_s[WIDTH];
    end else if (count_s) begin
      count_nxt_s = step_next_s;
      lim_nxt_s   = hit_s;
      wrap_nxt_s  = wrap_s;
      if (is_pingpong(mode_s)) begin
        dir_nxt_s = wrap_s ? ~dir_r : dir_r;
      end else begin
        dir_nxt_s = bus.UpDownMode;
      end
    end else begin
      count_nxt_s = count_r;
      dir_nxt_s   = dir_r;
      lim_nxt_s   = lim_r;
    end
  end

  // Counter state registers with asynchronous reset.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count_r <= MIN_W;
      dir_r   <= 1'b1;
      lim_r   <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      dir_r   <= dir_nxt_s;
      lim_r   <= lim_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign bus.Output           = count_r;
  assign bus.Direction        = dir_r;
  assign bus.LimitReachedFlag = lim_r;
  assign bus.WrapPulse        = wrap_r;

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Self-checking bench: directed vector table, async reset sequence, randomized run against a model.
module tb_bounded_updown_counter;

  localparam int W    = 8;
  localparam int MINV = 10;
  localparam int MAXV = 20;

  typedef struct {
    bit       clr;
    bit       ld;
    bit [7:0] lv;
    bit       en;
    bit       ud;
    bit [1:0] md;
    bit [7:0] st;
    int       e_out;
    int       e_dir;
    int       e_lim;
    int       e_wrap;
  } vec_t;

  logic Clk    = 1'b0;
  logic ResetN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  int m_out;
  bit m_dir;
  bit m_lim;
  bit m_wrap;

  bounded_updown_counter_if #(.WIDTH(W)) bus ();

  bounded_updown_counter #(
    .WIDTH     (W),
    .MAX_VALUE (MAXV),
    .MIN_VALUE (MINV)
  ) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eo, input int ed, input int el, input int ew);
    chk({tag, ".out"},  32'(bus.Output),           32'(eo));
    chk({tag, ".dir"},  32'(bus.Direction),        32'(ed));
    chk({tag, ".lim"},  32'(bus.LimitReachedFlag), 32'(el));
    chk({tag, ".wrap"}, 32'(bus.WrapPulse),        32'(ew));
  endtask

  task automatic add(input int c, input int l, input int lv, input int e, input int u,
                     input int md, input int st, input int eo, input int ed, input int el,
                     input int ew);
    vec_t v;
    v.clr = (c != 0);   v.ld = (l != 0);   v.lv = 8'(lv);
    v.en  = (e != 0);   v.ud = (u != 0);   v.md = 2'(md);   v.st = 8'(st);
    v.e_out = eo; v.e_dir = ed; v.e_lim = el; v.e_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit c, input bit l, input bit [7:0] lv, input bit e,
                       input bit u, input bit [1:0] md, input bit [7:0] st);
    bus.Clear = c; bus.Load = l; bus.LoadValue = lv; bus.Enable = e;
    bus.UpDownMode = u; bus.Mode = md; bus.Step = st;
  endtask

  task automatic model_reset();
    m_out = MINV; m_dir = 1'b1; m_lim = 1'b0; m_wrap = 1'b0;
  endtask

  // Reference behaviour from the counting rules, in plain integer arithmetic.
  task automatic model_edge(input bit c, input bit l, input int lv, input bit e,
                            input bit u, input int md, input int st);
    int s;
    int t;
    int rng;
    rng    = MAXV - MINV + 1;
    m_wrap = 1'b0;
    if (c) begin
      m_out = MINV; m_dir = u; m_lim = 1'b0;
    end else if (l) begin
      m_dir = u;
      if (lv > MAXV) begin m_out = MAXV; m_lim = 1'b1; end
      else if (lv < MINV) begin m_out = MINV; m_lim = 1'b1; end
      else begin m_out = lv; m_lim = 1'b0; end
    end else if (e && st != 0) begin
      s = (st > MAXV - MINV) ? MAXV - MINV : st;
      if (md == 2) begin
        t = m_dir ? m_out + s : m_out - s;
        if (m_dir && t >= MAXV) begin
          m_out = MAXV; m_dir = 1'b0; m_lim = 1'b1; m_wrap = 1'b1;
        end else if (!m_dir && t <= MINV) begin
          m_out = MINV; m_dir = 1'b1; m_lim = 1'b1; m_wrap = 1'b1;
        end else begin
          m_out = t; m_lim = 1'b0;
        end
      end else begin
        m_dir = u;
        t = u ? m_out + s : m_out - s;
        if (md == 1) begin
          if (t > MAXV) begin m_out = t - rng; m_lim = 1'b1; m_wrap = 1'b1; end
          else if (t < MINV) begin m_out = t + rng; m_lim = 1'b1; m_wrap = 1'b1; end
          else begin m_out = t; m_lim = 1'b0; end
        end else begin
          if (t >= MAXV) begin m_out = MAXV; m_lim = 1'b1; end
          else if (t <= MINV) begin m_out = MINV; m_lim = 1'b1; end
          else begin m_out = t; m_lim = 1'b0; end
        end
      end
    end
  endtask

  initial begin
    bit       r_c, r_l, r_e, r_u;
    bit [7:0] r_lv, r_st;
    bit [1:0] r_md;

    // clr ld lv en ud md st | out dir lim wrap
    add(0,1,18,0,1,0,3,   18,1,0,0);
    add(0,0, 0,1,1,0,3,   20,1,1,0);
    add(0,0, 0,1,1,0,3,   20,1,1,0);
    add(0,0, 0,0,1,0,3,   20,1,1,0);
    add(0,0, 0,0,1,0,3,   20,1,1,0);
    add(0,0, 0,0,1,0,3,   20,1,1,0);
    add(0,0, 0,1,1,0,0,   20,1,1,0);
    add(0,0, 0,1,1,0,0,   20,1,1,0);
    add(0,1,12,0,0,1,5,   12,0,0,0);
    add(0,0, 0,1,0,1,5,   18,0,1,1);
    add(0,0, 0,0,0,1,5,   18,0,1,0);
    add(0,0, 0,1,0,1,5,   13,0,0,0);
    add(0,1,15,0,1,1,5,   15,1,0,0);
    add(0,0, 0,1,1,1,5,   20,1,0,0);
    add(0,0, 0,1,1,1,5,   14,1,1,1);
    add(0,1,17,0,1,2,2,   17,1,0,0);
    add(0,0, 0,1,1,2,2,   19,1,0,0);
    add(0,0, 0,1,1,2,2,   20,0,1,1);
    add(0,0, 0,1,1,2,2,   18,0,0,0);
    add(0,0, 0,1,1,2,2,   16,0,0,0);
    add(0,0, 0,1,1,2,2,   14,0,0,0);
    add(0,0, 0,1,1,2,2,   12,0,0,0);
    add(0,0, 0,1,1,2,2,   10,1,1,1);
    add(0,0, 0,1,1,2,2,   12,1,0,0);
    add(1,1,15,1,0,0,3,   10,0,0,0);
    add(0,1,25,0,1,0,3,   20,1,1,0);
    add(0,1, 3,0,1,0,3,   10,1,1,0);
    add(0,1,13,0,0,0,3,   13,0,0,0);
    add(0,0, 0,1,0,0,3,   10,0,1,0);
    add(0,1,10,0,1,1,200, 10,1,0,0);
    add(0,0, 0,1,1,1,200, 20,1,0,0);
    add(0,0, 0,1,1,1,200, 19,1,1,1);
    add(0,1,19,0,1,2,2,   19,1,0,0);
    add(0,0, 0,1,1,2,2,   20,0,1,1);
    add(0,0, 0,1,1,0,2,   20,1,1,0);
    add(0,1,18,0,1,3,3,   18,1,0,0);
    add(0,0, 0,1,1,3,3,   20,1,1,0);

    drive(0, 0, 8'd0, 0, 1, 2'd0, 8'd1);
    #12;
    chk_all("reset", MINV, 1, 0, 0);
    ResetN = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud, vecs[i].md, vecs[i].st);
      @(posedge Clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_dir, vecs[i].e_lim, vecs[i].e_wrap);
    end

    // Asynchronous reset landing between edges right after a wrap.
    drive(0, 1, 8'd11, 0, 0, 2'd1, 8'd3);
    @(posedge Clk); #1;
    chk_all("ar_load", 11, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 2'd1, 8'd3);
    @(posedge Clk); #1;
    chk_all("ar_wrap", 19, 0, 1, 1);
    #2 ResetN = 1'b0;
    #1;
    chk_all("ar_now", MINV, 1, 0, 0);
    @(posedge Clk); #1;
    chk_all("ar_held", MINV, 1, 0, 0);
    #3 ResetN = 1'b1;
    @(posedge Clk); #1;
    chk_all("ar_first", 18, 0, 1, 1);

    // Randomized run against the reference model.
    #2 ResetN = 1'b0;
    model_reset();
    drive(0, 0, 8'd0, 0, 1, 2'd0, 8'd1);
    #4 ResetN = 1'b1;
    for (int n = 0; n < 600; n++) begin
      r_c  = ($urandom_range(0, 15) == 0);
      r_l  = ($urandom_range(0, 7) == 0);
      r_e  = ($urandom_range(0, 3) != 0);
      r_u  = 1'($urandom_range(0, 1));
      r_md = 2'($urandom_range(0, 3));
      r_lv = 8'($urandom_range(0, 255));
      r_st = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      drive(r_c, r_l, r_lv, r_e, r_u, r_md, r_st);
      model_edge(r_c, r_l, int'(r_lv), r_e, r_u, int'(r_md), int'(r_st));
      @(posedge Clk); #1;
      chk_all($sformatf("rnd%0d", n), m_out, int'(m_dir), int'(m_lim), int'(m_wrap));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
